// File: rtl/rf_multiport.sv
// Parametrised N-read / 1-write register file with registered reads, write-to-read
// bypass, optional hard-wired zero entry and a post-reset sequential clear sweep.
module rf_multiport #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           read_enabled,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    input  logic                           write_enabled,
    input  logic [ADDR_WIDTH-1:0]          write_addr,
    input  logic [DATA_WIDTH-1:0]          write_data,
    output logic                           init_done,
    output logic                           write_dropped
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_clear_ptr;
    logic [ADDR_WIDTH-1:0]   w_clear_ptr_next;
    logic                    r_init_done;
    logic                    w_init_done_next;
    logic                    r_write_dropped;
    logic                    w_write_dropped_next;
    logic                    w_addr_zero;
    logic                    w_wr_accept;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_waddr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    // The clear sweep and user writes share the single array write port.
    always_comb begin
        w_state_next         = r_state;
        w_clear_ptr_next     = r_clear_ptr;
        w_init_done_next     = r_init_done;
        w_write_dropped_next = 1'b0;
        w_wr_accept          = 1'b0;
        w_mem_we             = 1'b0;
        w_mem_waddr          = write_addr;
        w_mem_wdata          = write_data;
        w_addr_zero          = (ZERO_REG != 0) && (write_addr == '0);
        case (r_state)
            CLEAR: begin
                w_mem_we             = 1'b1;
                w_mem_waddr          = r_clear_ptr;
                w_mem_wdata          = '0;
                w_clear_ptr_next     = r_clear_ptr + 1'b1;
                w_write_dropped_next = write_enabled;
                if (r_clear_ptr == '1) begin
                    w_state_next     = READY;
                    w_init_done_next = 1'b1;
                end
            end
            READY: begin
                w_wr_accept          = write_enabled && !w_addr_zero;
                w_mem_we             = w_wr_accept;
                w_write_dropped_next = write_enabled && w_addr_zero;
            end
            default: w_state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= CLEAR;
            r_clear_ptr     <= '0;
            r_init_done     <= 1'b0;
            r_write_dropped <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_clear_ptr     <= w_clear_ptr_next;
            r_init_done     <= w_init_done_next;
            r_write_dropped <= w_write_dropped_next;
        end
    end

    // No reset on the array itself so it can map onto block RAM.
    always_ff @(posedge clock) begin
        if (w_mem_we && !reset) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_raddr;
        logic [DATA_WIDTH-1:0] w_rvalue;
        logic [DATA_WIDTH-1:0] r_rdata;

        assign w_raddr = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_rvalue = r_mem[w_raddr];
            if ((BYPASS != 0) && w_wr_accept && (w_raddr == write_addr)) begin
                w_rvalue = write_data;
            end
            if ((ZERO_REG != 0) && (w_raddr == '0)) begin
                w_rvalue = '0;
            end
        end

        always_ff @(posedge clock) begin
            if (reset || (r_state == CLEAR)) begin
                r_rdata <= '0;
            end else if (read_enabled) begin
                r_rdata <= w_rvalue;
            end
        end

        assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = r_rdata;
    end

    assign init_done     = r_init_done;
    assign write_dropped = r_write_dropped;

endmodule
